// File: rtl/wbs_mem_ctrl_if.sv
// Wishbone classic slave-side bus bundle between the Caravel master and wbs_mem_ctrl.
// Signal names follow the slave's point of view (_i driven by master, _o driven by slave).
interface wbs_mem_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wbs_mem_ctrl.sv
// Wishbone slave fronting the KD-tree ANN core: CSRs, 32->64 bit SRAM write packing,
// one-cycle SRAM reads, start pulse; memory traffic is refused while the core is busy.
module wbs_mem_ctrl #(
  parameter logic [11:0] ADDR_BASE = 12'h300,
  parameter int          MEM_AW    = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  wbs_mem_ctrl_if.slave     wbs,
  output logic [3:0]        mem_sel,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              wb_owns_mem,
  output logic              mode,
  output logic              debug,
  output logic              fsm_start,
  input  logic              core_busy,
  input  logic              core_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ACK,
    S_RD_WAIT,
    S_RD_ACK,
    S_GAP
  } state_t;

  state_t              state_q;
  logic                ack_q;
  logic [31:0]         dat_q;
  logic [31:0]         hold_q;
  logic                mode_q;
  logic                debug_q;
  logic                err_q;
  logic                start_q;
  logic                csb_q;
  logic                web_q;
  logic [3:0]          sel_q;
  logic [MEM_AW-1:0]   addr_q;
  logic [63:0]         wdata_q;
  logic                rd_hi_q;

  logic                hit;
  logic [3:0]          region;
  logic                is_csr;
  logic                is_mem;
  logic [3:0]          sel_dec;
  logic [31:0]         csr_rdata;
  logic [MEM_AW-1:0]   word_idx;
  logic                half_hi;

  logic unused_sel;
  assign unused_sel = ^wbs.wbs_sel_i;

  always_comb begin
    hit      = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:20] == ADDR_BASE);
    region   = wbs.wbs_adr_i[19:16];
    is_csr   = (region == 4'd0);
    is_mem   = (region >= 4'd1) && (region <= 4'd4);
    word_idx = wbs.wbs_adr_i[3 +: MEM_AW];
    half_hi  = wbs.wbs_adr_i[2];

    sel_dec = 4'b0000;
    case (region)
      4'd1:    sel_dec = 4'b0001;
      4'd2:    sel_dec = 4'b0010;
      4'd3:    sel_dec = 4'b0100;
      4'd4:    sel_dec = 4'b1000;
      default: sel_dec = 4'b0000;
    endcase

    csr_rdata = 32'd0;
    case (wbs.wbs_adr_i[7:0])
      8'h00:   csr_rdata = {31'd0, mode_q};
      8'h04:   csr_rdata = {30'd0, err_q, debug_q};
      8'h08:   csr_rdata = {31'd0, core_done};
      8'h10:   csr_rdata = {31'd0, core_busy};
      default: csr_rdata = 32'd0;
    endcase
  end

  // Strobes (ack, start, chip select) default inactive every cycle so each lasts one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      hold_q  <= 32'd0;
      mode_q  <= 1'b0;
      debug_q <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      sel_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 64'd0;
      rd_hi_q <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (hit) begin
            if (is_mem && !wbs.wbs_we_i && !core_busy) begin
              csb_q   <= 1'b0;
              sel_q   <= sel_dec;
              addr_q  <= word_idx;
              rd_hi_q <= half_hi;
              state_q <= S_RD_WAIT;
            end else begin
              ack_q   <= 1'b1;
              state_q <= S_WR_ACK;
              if (is_csr) begin
                if (wbs.wbs_we_i) begin
                  case (wbs.wbs_adr_i[7:0])
                    8'h00: mode_q <= wbs.wbs_dat_i[0];
                    8'h04: begin
                      debug_q <= wbs.wbs_dat_i[0];
                      if (wbs.wbs_dat_i[1]) begin
                        err_q <= 1'b0;
                      end
                    end
                    8'h0C: start_q <= ~core_busy;
                    default: ;
                  endcase
                end else begin
                  dat_q <= csr_rdata;
                end
              end else if (is_mem) begin
                if (core_busy) begin
                  // The SRAMs belong to the core: refuse, flag, but still ack.
                  err_q <= 1'b1;
                  if (!wbs.wbs_we_i) begin
                    dat_q <= 32'd0;
                  end
                end else if (half_hi) begin
                  csb_q   <= 1'b0;
                  web_q   <= 1'b0;
                  sel_q   <= sel_dec;
                  addr_q  <= word_idx;
                  wdata_q <= {wbs.wbs_dat_i, hold_q};
                end else begin
                  hold_q <= wbs.wbs_dat_i;
                end
              end else if (!wbs.wbs_we_i) begin
                dat_q <= 32'd0;
              end
            end
          end
        end
        S_WR_ACK: state_q <= S_GAP;
        S_RD_WAIT: state_q <= S_RD_ACK;
        S_RD_ACK: begin
          dat_q   <= rd_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
          ack_q   <= 1'b1;
          state_q <= S_GAP;
        end
        // One dead cycle so a request still held after the ack is not re-sampled.
        S_GAP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign mem_sel       = sel_q;
  assign mem_csb       = csb_q;
  assign mem_web       = web_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mode          = mode_q;
  assign debug         = debug_q;
  assign fsm_start     = start_q;
  assign wb_owns_mem   = ~core_busy;

endmodule

// File: tb/tb_wbs_mem_ctrl.sv
// Self-checking bench for wbs_mem_ctrl: directed scenarios plus a randomized
// bus-traffic run scored against a register/memory-map reference model.
module tb_wbs_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mem_sel;
  logic        mem_csb, mem_web;
  logic [12:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        wb_owns_mem, mode, debug, fsm_start;
  logic        core_busy, core_done;

  always #5 clk = ~clk;

  wbs_mem_ctrl_if bus();

  wbs_mem_ctrl #(.ADDR_BASE(12'h300), .MEM_AW(13)) dut (
    .clk(clk), .rst_n(rst_n), .wbs(bus),
    .mem_sel(mem_sel), .mem_csb(mem_csb), .mem_web(mem_web),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_owns_mem(wb_owns_mem), .mode(mode), .debug(debug), .fsm_start(fsm_start),
    .core_busy(core_busy), .core_done(core_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // SRAM environment: one-cycle synchronous memories, keyed by region*8192+word.
  logic [63:0] sram [int];
  int          sram_wr_cnt = 0;
  int          sram_rd_cnt = 0;
  int          start_cnt   = 0;
  logic [3:0]  last_wr_sel;
  logic [12:0] last_wr_addr;
  logic [63:0] last_wr_data;

  function automatic int sel_region(input logic [3:0] s);
    case (s)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 3;
      4'b1000: return 4;
      default: return 0;
    endcase
  endfunction

  initial mem_rdata = 64'd0;

  always @(posedge clk) begin
    if (fsm_start === 1'b1) start_cnt++;
    if (mem_csb === 1'b0) begin
      int k;
      k = sel_region(mem_sel) * 8192 + int'(mem_addr);
      if (mem_web === 1'b0) begin
        sram[k]      = mem_wdata;
        sram_wr_cnt++;
        last_wr_sel  = mem_sel;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end else begin
        sram_rd_cnt++;
        mem_rdata <= sram.exists(k) ? sram[k] : 64'd0;
      end
    end
  end

  // Reference model of the slave's architectural state.
  logic [63:0] ref_mem [int];
  logic [31:0] ref_hold;
  logic        ref_mode, ref_debug, ref_err;

  task automatic bus_op(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input int budget, output logic [31:0] rd, output int lat,
                        output logic ack_after);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    lat = -1;
    rd = 32'd0;
    ack_after = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o === 1'b1) begin
        lat = i;
        rd  = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    if (lat > 0) begin
      @(posedge clk); #1;
      ack_after = bus.wbs_ack_o;
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
    core_busy = 1'b0; core_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_hold = 32'd0; ref_mode = 1'b0; ref_debug = 1'b0; ref_err = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat; logic aa;
    apply_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({bus.wbs_ack_o, mem_csb, mem_web, mode, debug, fsm_start} !== 6'b011000) begin
      n_fail++;
      $display("FAIL reset_ctl: got ack/csb/web/mode/debug/start=%b want 011000",
               {bus.wbs_ack_o, mem_csb, mem_web, mode, debug, fsm_start});
    end
    n_checks++;
    if ({bus.wbs_dat_o, mem_sel, mem_addr, mem_wdata} !== 113'd0) begin
      n_fail++;
      $display("FAIL reset_data: dat_o=%h sel=%b addr=%h wdata=%h want all 0",
               bus.wbs_dat_o, mem_sel, mem_addr, mem_wdata);
    end
    n_checks++;
    if (wb_owns_mem !== 1'b1) begin
      n_fail++; $display("FAIL reset_owns: got %b want 1", wb_owns_mem);
    end
    bus_op(1'b0, 32'h3000_0004, 32'd0, 5, rd, lat, aa);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++; $display("FAIL reset_debug_rd: got %h want 0", rd);
    end
  endtask

  task automatic test_csr_debug();
    logic [31:0] rd; int lat; logic aa;
    bus_op(1'b1, 32'h3000_0004, 32'h1, 10, rd, lat, aa);
    n_checks++;
    if (lat !== 1 || aa !== 1'b0) begin
      n_fail++; $display("FAIL dbg_wr_ack: lat=%0d ack_after=%b want 1/0", lat, aa);
    end
    n_checks++;
    if (debug !== 1'b1) begin
      n_fail++; $display("FAIL dbg_out: got %b want 1", debug);
    end
    bus_op(1'b0, 32'h3000_0004, 32'd0, 10, rd, lat, aa);
    n_checks++;
    if (rd !== 32'h1 || lat !== 1) begin
      n_fail++; $display("FAIL dbg_rd: got %h lat %0d want 1 lat 1", rd, lat);
    end
  endtask

  task automatic test_pack_write();
    logic [31:0] rd; int lat; logic aa; int w0;
    w0 = sram_wr_cnt;
    bus_op(1'b1, 32'h3002_0010, 32'h0012_3456, 10, rd, lat, aa);
    n_checks++;
    if (sram_wr_cnt !== w0 || lat !== 1) begin
      n_fail++; $display("FAIL pack_lo: writes=%0d lat=%0d want 0 writes lat 1", sram_wr_cnt - w0, lat);
    end
    bus_op(1'b1, 32'h3002_0014, 32'h0000_ABCD, 10, rd, lat, aa);
    n_checks++;
    if (sram_wr_cnt - w0 !== 1) begin
      n_fail++; $display("FAIL pack_cnt: got %0d SRAM writes want 1", sram_wr_cnt - w0);
    end
    n_checks++;
    if (last_wr_sel !== 4'b0010 || last_wr_addr !== 13'd2 || last_wr_data !== 64'h0000ABCD_00123456) begin
      n_fail++;
      $display("FAIL pack_word: sel=%b addr=%0d data=%h want 0010 2 0000abcd00123456",
               last_wr_sel, last_wr_addr, last_wr_data);
    end
    ref_mem[2 * 8192 + 2] = 64'h0000ABCD_00123456;
    ref_hold = 32'h0012_3456;
  endtask

  task automatic test_read();
    logic [31:0] rd; int lat; logic aa;
    sram[3 * 8192 + 1]    = 64'hCAFE0001_0BAD0002;
    ref_mem[3 * 8192 + 1] = 64'hCAFE0001_0BAD0002;
    bus_op(1'b0, 32'h3003_0008, 32'd0, 10, rd, lat, aa);
    n_checks++;
    if (rd !== 32'h0BAD0002 || lat !== 3) begin
      n_fail++; $display("FAIL rd_lo: got %h lat %0d want 0bad0002 lat 3", rd, lat);
    end
    n_checks++;
    if (aa !== 1'b0) begin
      n_fail++; $display("FAIL rd_ack_len: ack still %b after one cycle want 0", aa);
    end
    bus_op(1'b0, 32'h3003_000C, 32'd0, 10, rd, lat, aa);
    n_checks++;
    if (rd !== 32'hCAFE0001 || lat !== 3) begin
      n_fail++; $display("FAIL rd_hi: got %h lat %0d want cafe0001 lat 3", rd, lat);
    end
    n_checks++;
    if (bus.wbs_dat_o !== 32'hCAFE0001) begin
      n_fail++; $display("FAIL rd_hold: dat_o %h want cafe0001", bus.wbs_dat_o);
    end
  endtask

  task automatic test_fsm_start();
    logic [31:0] rd; int lat; logic aa; int s0;
    s0 = start_cnt;
    bus_op(1'b1, 32'h3000_000C, 32'h1, 10, rd, lat, aa);
    n_checks++;
    if (start_cnt - s0 !== 1) begin
      n_fail++; $display("FAIL start_pulse: got %0d cycles want 1", start_cnt - s0);
    end
    core_busy = 1'b1;
    s0 = start_cnt;
    bus_op(1'b1, 32'h3000_000C, 32'h1, 10, rd, lat, aa);
    n_checks++;
    if (start_cnt - s0 !== 0 || lat !== 1) begin
      n_fail++; $display("FAIL start_busy: got %0d cycles lat %0d want 0 lat 1", start_cnt - s0, lat);
    end
    core_busy = 1'b0;
  endtask

  task automatic test_busy_reject();
    logic [31:0] rd; int lat; logic aa; int r0;
    core_busy = 1'b1;
    #1;
    n_checks++;
    if (wb_owns_mem !== 1'b0) begin
      n_fail++; $display("FAIL busy_owns: got %b want 0", wb_owns_mem);
    end
    r0 = sram_rd_cnt;
    bus_op(1'b0, 32'h3001_0000, 32'd0, 10, rd, lat, aa);
    n_checks++;
    if (rd !== 32'd0 || lat !== 1 || sram_rd_cnt !== r0) begin
      n_fail++; $display("FAIL busy_rd: data %h lat %0d sram_rd %0d want 0 lat 1 none", rd, lat, sram_rd_cnt - r0);
    end
    bus_op(1'b0, 32'h3000_0004, 32'd0, 10, rd, lat, aa);
    n_checks++;
    if (rd[1] !== 1'b1) begin
      n_fail++; $display("FAIL busy_err_set: debug reg %h want bit1=1", rd);
    end
    bus_op(1'b1, 32'h3000_0004, 32'h2, 10, rd, lat, aa);
    bus_op(1'b0, 32'h3000_0004, 32'd0, 10, rd, lat, aa);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++; $display("FAIL busy_err_clr: debug reg %h want 0", rd);
    end
    core_busy = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] rd; int lat; logic aa; logic ack_seen;
    bus_op(1'b1, 32'h3000_0004, 32'h1, 10, rd, lat, aa);
    bus_op(1'b0, 32'h3000_0004, 32'd0, 10, rd, lat, aa);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h3003_0008;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_csb !== 1'b1 || bus.wbs_dat_o !== 32'd0 || bus.wbs_ack_o !== 1'b0 || debug !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: csb=%b dat_o=%h ack=%b debug=%b want 1 0 0 0",
               mem_csb, bus.wbs_dat_o, bus.wbs_ack_o, debug);
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_hold = 32'd0; ref_mode = 1'b0; ref_debug = 1'b0; ref_err = 1'b0;
    ack_seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o === 1'b1) ack_seen = 1'b1;
    end
    n_checks++;
    if (ack_seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_ack: ack seen %b want 0", ack_seen);
    end
    bus_op(1'b1, 32'h3000_0000, 32'h1, 10, rd, lat, aa);
    n_checks++;
    if (lat !== 1 || mode !== 1'b1) begin
      n_fail++; $display("FAIL rst_recover: lat %0d mode %b want 1 1", lat, mode);
    end
    ref_mode = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] rd, adr, dat, exp; int lat, expl; logic aa;
    int kind, r, w, hi, w0, r0, s0, k;
    logic [7:0] off;
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 6);
      core_busy = ($urandom_range(0, 4) == 0);
      core_done = 1'($urandom);
      dat = $urandom;
      r = $urandom_range(1, 4);
      w = $urandom_range(0, 7);
      hi = (kind == 1) ? 1 : $urandom_range(0, 1);
      adr = 32'h3000_0000 | (r << 16) | (w << 3) | (hi << 2);
      k = r * 8192 + w;
      w0 = sram_wr_cnt; r0 = sram_rd_cnt; s0 = start_cnt;
      case (kind)
        0, 1: begin
          if (kind == 0) adr[2] = 1'b0;
          bus_op(1'b1, adr, dat, 10, rd, lat, aa);
          expl = 0;
          if (core_busy) ref_err = 1'b1;
          else if (adr[2]) begin ref_mem[k] = {dat, ref_hold}; expl = 1; end
          else ref_hold = dat;
          n_checks++;
          if (lat !== 1 || sram_wr_cnt - w0 !== expl) begin
            n_fail++; $display("FAIL rnd_wr[%0d]: lat %0d writes %0d want 1 %0d", n, lat, sram_wr_cnt - w0, expl);
          end else if (expl == 1) begin
            n_checks++;
            if (last_wr_data !== ref_mem[k] || last_wr_sel !== 4'(1 << (r - 1)) || last_wr_addr !== 13'(w)) begin
              n_fail++;
              $display("FAIL rnd_wr_word[%0d]: sel %b addr %0d data %h want region %0d word %0d %h",
                       n, last_wr_sel, last_wr_addr, last_wr_data, r, w, ref_mem[k]);
            end
          end
        end
        2, 3: begin
          bus_op(1'b0, adr, 32'd0, 10, rd, lat, aa);
          if (core_busy) begin
            ref_err = 1'b1; exp = 32'd0; expl = 1;
          end else begin
            exp = ref_mem.exists(k) ? (hi ? ref_mem[k][63:32] : ref_mem[k][31:0]) : 32'd0;
            expl = 3;
          end
          n_checks++;
          if (rd !== exp || lat !== expl || sram_rd_cnt - r0 !== (core_busy ? 0 : 1)) begin
            n_fail++; $display("FAIL rnd_rd[%0d]: data %h lat %0d want %h lat %0d", n, rd, lat, exp, expl);
          end
        end
        4: begin
          off = 8'($urandom_range(0, 2) * 4);
          if (off == 8'h08) off = 8'h0C;
          bus_op(1'b1, 32'h3000_0000 | 32'(off), dat, 10, rd, lat, aa);
          if (off == 8'h00) ref_mode = dat[0];
          if (off == 8'h04) begin ref_debug = dat[0]; if (dat[1]) ref_err = 1'b0; end
          n_checks++;
          if (lat !== 1 || mode !== ref_mode || debug !== ref_debug ||
              start_cnt - s0 !== ((off == 8'h0C && !core_busy) ? 1 : 0)) begin
            n_fail++; $display("FAIL rnd_csr_wr[%0d]: off %h lat %0d mode %b debug %b starts %0d",
                               n, off, lat, mode, debug, start_cnt - s0);
          end
        end
        5: begin
          off = 8'($urandom_range(0, 5) * 4);
          bus_op(1'b0, 32'h3000_0000 | 32'(off), 32'd0, 10, rd, lat, aa);
          case (off)
            8'h00:   exp = {31'd0, ref_mode};
            8'h04:   exp = {30'd0, ref_err, ref_debug};
            8'h08:   exp = {31'd0, core_done};
            8'h10:   exp = {31'd0, core_busy};
            default: exp = 32'd0;
          endcase
          n_checks++;
          if (rd !== exp || lat !== 1) begin
            n_fail++; $display("FAIL rnd_csr_rd[%0d]: off %h got %h lat %0d want %h", n, off, rd, lat, exp);
          end
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            adr[19:16] = 4'($urandom_range(5, 15));
            bus_op(hi[0], adr, dat, 10, rd, lat, aa);
            n_checks++;
            if (lat !== 1 || (hi == 0 && rd !== 32'd0) || sram_wr_cnt !== w0 || sram_rd_cnt !== r0) begin
              n_fail++; $display("FAIL rnd_unmapped[%0d]: adr %h lat %0d data %h", n, adr, lat, rd);
            end
          end else begin
            adr[31:20] = 12'h301 + 12'($urandom_range(0, 200));
            bus_op(hi[0], adr, dat, 5, rd, lat, aa);
            n_checks++;
            if (lat !== -1 || sram_wr_cnt !== w0 || sram_rd_cnt !== r0) begin
              n_fail++; $display("FAIL rnd_miss[%0d]: adr %h acked lat %0d want no ack", n, adr, lat);
            end
          end
        end
      endcase
    end
    core_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_csr_debug();
    test_pack_write();
    test_read();
    test_fsm_start();
    test_busy_reject();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
